// File: rtl/miner_pkg.sv
// Purpose: shared types and default sizes for the nonce dispatcher.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package miner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_DONE     = 2'd3
  } dispatch_state_t;

  localparam int DEF_CORES   = 4;
  localparam int DEF_NONCE_W = 32;

endpackage

// File: rtl/miner_rr_arbiter.sv
// Purpose: round-robin pick of the first eligible core at or after ptr.
// Latency: purely combinational, zero cycles.
// Backpressure: none; ineligible cores are simply never selected.
module miner_rr_arbiter
  import miner_pkg::*;
#(
  parameter int CORES = DEF_CORES,
  localparam int IDX_W = $clog2(CORES)
) (
  input  logic [CORES-1:0] elig,
  input  logic [IDX_W-1:0] ptr,
  output logic             gnt_any,
  output logic [CORES-1:0] gnt_onehot,
  output logic [IDX_W-1:0] gnt_idx
);

  // Scan from farthest to nearest offset so the closest eligible core at or after ptr wins.
  always_comb begin
    int j;
    gnt_any    = 1'b0;
    gnt_onehot = '0;
    gnt_idx    = '0;
    j          = 0;
    for (int k = CORES - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % CORES;
      if (elig[j]) begin
        gnt_any = 1'b1;
        gnt_idx = IDX_W'(j);
      end
    end
    if (gnt_any) gnt_onehot[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/miner_nonce_dispatch.sv
// Purpose: hand out nonces round-robin to hash cores, report winner or exhaustion.
// Latency: grant registered one cycle after an eligible request; found/done reported one cycle after the pulse.
// Backpressure: cores hold core_req until granted; busy cores are masked until core_done.
module miner_nonce_dispatch
  import miner_pkg::*;
#(
  parameter int CORES   = DEF_CORES,
  parameter int NONCE_W = DEF_NONCE_W,
  localparam int IDX_W  = $clog2(CORES)
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               job_start,
  input  logic               job_abort,
  input  logic [CORES-1:0]   core_req,
  input  logic [CORES-1:0]   core_done,
  input  logic [CORES-1:0]   core_found,
  output logic [CORES-1:0]   core_grant,
  output logic [NONCE_W-1:0] grant_nonce,
  output logic               busy,
  output logic               done,
  output logic               success,
  output logic [IDX_W-1:0]   winner_id,
  output logic [NONCE_W-1:0] winner_nonce
);

  dispatch_state_t    state, state_nxt;
  logic [NONCE_W-1:0] cnt, cnt_nxt;
  logic [IDX_W-1:0]   ptr, ptr_nxt;
  logic [CORES-1:0]   busy_bits, busy_nxt;
  logic [NONCE_W-1:0] assigned     [CORES];
  logic [NONCE_W-1:0] assigned_nxt [CORES];
  logic [CORES-1:0]   grant_nxt;
  logic [NONCE_W-1:0] gnonce_nxt, wnonce_nxt;
  logic               done_nxt, success_nxt;
  logic [IDX_W-1:0]   wid_nxt, low_idx;
  logic [CORES-1:0]   found_vec, elig;
  logic               arb_any;
  logic [CORES-1:0]   arb_onehot;
  logic [IDX_W-1:0]   arb_idx;

  // Reports from cores that hold no nonce are meaningless and dropped.
  assign found_vec = core_found & busy_bits;
  assign elig      = core_req & ~busy_bits;
  assign busy      = (state == ST_DISPATCH) || (state == ST_DRAIN);

  miner_rr_arbiter #(.CORES(CORES)) u_arb (
    .elig       (elig),
    .ptr        (ptr),
    .gnt_any    (arb_any),
    .gnt_onehot (arb_onehot),
    .gnt_idx    (arb_idx)
  );

  // Lowest-index finder wins when several cores hit in the same cycle.
  always_comb begin
    low_idx = '0;
    for (int i = CORES - 1; i >= 0; i--) begin
      if (found_vec[i]) low_idx = IDX_W'(i);
    end
  end

  // Next-state, grant and result computation; abort overrides everything.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    ptr_nxt      = ptr;
    busy_nxt     = busy_bits & ~core_done;
    assigned_nxt = assigned;
    grant_nxt    = '0;
    gnonce_nxt   = '0;
    done_nxt     = done;
    success_nxt  = success;
    wid_nxt      = winner_id;
    wnonce_nxt   = winner_nonce;
    if (job_abort) begin
      state_nxt = ST_IDLE;
      busy_nxt  = '0;
      done_nxt  = 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (job_start) begin
            state_nxt   = ST_DISPATCH;
            cnt_nxt     = '0;
            ptr_nxt     = '0;
            busy_nxt    = '0;
            done_nxt    = 1'b0;
            success_nxt = 1'b0;
            wid_nxt     = '0;
            wnonce_nxt  = '0;
          end
        end
        ST_DISPATCH, ST_DRAIN: begin
          if (|found_vec) begin
            state_nxt   = ST_DONE;
            done_nxt    = 1'b1;
            success_nxt = 1'b1;
            wid_nxt     = low_idx;
            wnonce_nxt  = assigned[low_idx];
          end else if ((state == ST_DISPATCH) && arb_any) begin
            grant_nxt              = arb_onehot;
            gnonce_nxt             = cnt;
            assigned_nxt[arb_idx]  = cnt;
            busy_nxt[arb_idx]      = 1'b1;
            ptr_nxt                = IDX_W'((int'(arb_idx) + 1) % CORES);
            // The last nonce of the space ends dispatch; the counter never wraps.
            if (cnt == '1) state_nxt = ST_DRAIN;
            else           cnt_nxt   = cnt + 1'b1;
          end else if ((state == ST_DRAIN) && (busy_nxt == '0)) begin
            state_nxt   = ST_DONE;
            done_nxt    = 1'b1;
            success_nxt = 1'b0;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Datapath registers: counter, pointer, per-core tracking and registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt          <= '0;
      ptr          <= '0;
      busy_bits    <= '0;
      core_grant   <= '0;
      grant_nonce  <= '0;
      done         <= 1'b0;
      success      <= 1'b0;
      winner_id    <= '0;
      winner_nonce <= '0;
      for (int i = 0; i < CORES; i++) assigned[i] <= '0;
    end else begin
      cnt          <= cnt_nxt;
      ptr          <= ptr_nxt;
      busy_bits    <= busy_nxt;
      core_grant   <= grant_nxt;
      grant_nonce  <= gnonce_nxt;
      done         <= done_nxt;
      success      <= success_nxt;
      winner_id    <= wid_nxt;
      winner_nonce <= wnonce_nxt;
      for (int i = 0; i < CORES; i++) assigned[i] <= assigned_nxt[i];
    end
  end

endmodule

// File: tb/tb_miner_nonce_dispatch.sv
// Purpose: directed self-checking bench for the nonce dispatcher (4 cores, 4-bit nonces).
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: bench models cores dropping core_req after grant and pulsing core_done.
module tb_miner_nonce_dispatch;
  localparam int CORES   = 4;
  localparam int NONCE_W = 4;
  localparam int IDX_W   = 2;

  logic               clk = 1'b0;
  logic               n_rst = 1'b1;
  logic               job_start = 1'b0;
  logic               job_abort = 1'b0;
  logic [CORES-1:0]   core_req = '0;
  logic [CORES-1:0]   core_done = '0;
  logic [CORES-1:0]   core_found = '0;
  logic [CORES-1:0]   core_grant;
  logic [NONCE_W-1:0] grant_nonce;
  logic               busy, done, success;
  logic [IDX_W-1:0]   winner_id;
  logic [NONCE_W-1:0] winner_nonce;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  miner_nonce_dispatch #(.CORES(CORES), .NONCE_W(NONCE_W)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .job_start    (job_start),
    .job_abort    (job_abort),
    .core_req     (core_req),
    .core_done    (core_done),
    .core_found   (core_found),
    .core_grant   (core_grant),
    .grant_nonce  (grant_nonce),
    .busy         (busy),
    .done         (done),
    .success      (success),
    .winner_id    (winner_id),
    .winner_nonce (winner_nonce)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 n_rst = 1'b0;
    #3;
    n_checks++;
    if ({core_grant, grant_nonce, busy, done, success, winner_id, winner_nonce} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got grant=%b nonce=%0d busy=%b done=%b succ=%b, need all 0",
               core_grant, grant_nonce, busy, done, success);
    end
    tick();
    n_rst = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b need 0", busy); end
  endtask

  task automatic test_reset_mid_dispatch();
    core_req  = 4'b0001;
    job_start = 1'b1;
    tick();
    job_start = 1'b0;
    tick();
    n_checks++;
    if (core_grant !== 4'b0001 || grant_nonce !== 4'd0) begin
      n_fail++;
      $display("FAIL first_grant: got %b/%0d need 0001/0", core_grant, grant_nonce);
    end
    #2 n_rst = 1'b0;
    #1;
    n_checks++;
    if (core_grant !== 4'b0000 || busy !== 1'b0 || grant_nonce !== 4'd0) begin
      n_fail++;
      $display("FAIL async_reset: got grant=%b busy=%b nonce=%0d need 0", core_grant, busy, grant_nonce);
    end
    #2 n_rst = 1'b1;
    core_req = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (core_grant !== 4'b0000 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL no_grant_after_reset: got grant=%b busy=%b need 0000/0", core_grant, busy);
      end
    end
    core_req = '0;
  endtask

  task automatic test_round_robin();
    core_req  = 4'b1111;
    job_start = 1'b1;
    tick();
    job_start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || core_grant !== 4'b0000) begin
      n_fail++;
      $display("FAIL start_busy: got busy=%b grant=%b need 1/0000", busy, core_grant);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if (core_grant !== 4'(1 << k) || grant_nonce !== NONCE_W'(k)) begin
        n_fail++;
        $display("FAIL rr_grant%0d: got %b/%0d need %b/%0d", k, core_grant, grant_nonce, 4'(1 << k), k);
      end
      core_req[k] = 1'b0;
    end
    tick();
    n_checks++;
    if (core_grant !== 4'b0000 || grant_nonce !== 4'd0) begin
      n_fail++;
      $display("FAIL rr_idle: got %b/%0d need 0000/0", core_grant, grant_nonce);
    end
    core_done   = 4'b0001;
    core_req[0] = 1'b1;
    tick();
    core_done = '0;
    n_checks++;
    if (core_grant !== 4'b0000) begin n_fail++; $display("FAIL rr_done_cycle: got %b need 0000", core_grant); end
    tick();
    n_checks++;
    if (core_grant !== 4'b0001 || grant_nonce !== 4'd4) begin
      n_fail++;
      $display("FAIL rr_regrant: got %b/%0d need 0001/4", core_grant, grant_nonce);
    end
    core_req  = '0;
    job_abort = 1'b1;
    tick();
    job_abort = 1'b0;
  endtask

  task automatic test_exhaustion();
    int  grants;
    bit  seen_done;
    grants    = 0;
    seen_done = 1'b0;
    core_req  = 4'b1111;
    job_start = 1'b1;
    tick();
    job_start = 1'b0;
    for (int c = 0; c < 60 && !seen_done; c++) begin
      tick();
      if (core_grant !== 4'b0000) begin
        n_checks++;
        if (core_grant !== 4'(1 << (grants % 4)) || grant_nonce !== NONCE_W'(grants) || grants >= 16) begin
          n_fail++;
          $display("FAIL exh_grant%0d: got %b/%0d need %b/%0d", grants, core_grant, grant_nonce,
                   4'(1 << (grants % 4)), grants);
        end
        grants++;
        if (grants == 16) begin
          n_checks++;
          if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL exh_drain: got busy=%b done=%b need 1/0", busy, done);
          end
        end
      end
      core_done = core_grant;
      if (done === 1'b1) seen_done = 1'b1;
    end
    core_done = '0;
    n_checks++;
    if (!seen_done || grants != 16 || success !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL exh_done: got done_seen=%0d grants=%0d succ=%b busy=%b need 1/16/0/0",
               seen_done, grants, success, busy);
    end
    tick();
    n_checks++;
    if (core_grant !== 4'b0000 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL exh_hold: got grant=%b done=%b need 0000/1", core_grant, done);
    end
  endtask

  task automatic test_found();
    core_req  = 4'b1111;
    job_start = 1'b1;
    tick();
    job_start = 1'b0;
    n_checks++;
    if (done !== 1'b0 || success !== 1'b0) begin
      n_fail++;
      $display("FAIL found_restart_clear: got done=%b succ=%b need 0/0", done, success);
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      n_checks++;
      if (core_grant !== 4'(1 << (k % 4)) || grant_nonce !== NONCE_W'(k)) begin
        n_fail++;
        $display("FAIL found_setup%0d: got %b/%0d need %b/%0d", k, core_grant, grant_nonce, 4'(1 << (k % 4)), k);
      end
      core_done = (k < 4) ? core_grant : 4'b0000;
    end
    core_done = 4'b0001;
    tick();
    core_done = '0;
    n_checks++;
    if (core_grant !== 4'b0000) begin n_fail++; $display("FAIL found_pre: got %b need 0000", core_grant); end
    core_found = 4'b1100;
    tick();
    core_found = '0;
    n_checks++;
    if (done !== 1'b1 || success !== 1'b1 || winner_id !== 2'd2 || winner_nonce !== 4'd6) begin
      n_fail++;
      $display("FAIL found_result: got done=%b succ=%b id=%0d nonce=%0d need 1/1/2/6",
               done, success, winner_id, winner_nonce);
    end
    n_checks++;
    if (core_grant !== 4'b0000 || grant_nonce !== 4'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL found_nogrant: got grant=%b nonce=%0d busy=%b need 0000/0/0", core_grant, grant_nonce, busy);
    end
  endtask

  task automatic test_abort();
    core_req  = 4'b0011;
    job_start = 1'b1;
    tick();
    job_start = 1'b0;
    tick();
    core_req[0] = 1'b0;
    tick();
    n_checks++;
    if (core_grant !== 4'b0010 || grant_nonce !== 4'd1) begin
      n_fail++;
      $display("FAIL abort_setup: got %b/%0d need 0010/1", core_grant, grant_nonce);
    end
    core_req = '0;
    tick();
    job_abort = 1'b1;
    job_start = 1'b1;
    tick();
    job_abort = 1'b0;
    job_start = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || core_grant !== 4'b0000 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: got busy=%b grant=%b done=%b need 0/0000/0", busy, core_grant, done);
    end
    core_req = 4'b1111;
    tick();
    n_checks++;
    if (core_grant !== 4'b0000) begin n_fail++; $display("FAIL abort_nograntidle: got %b need 0000", core_grant); end
    job_start = 1'b1;
    tick();
    job_start = 1'b0;
    tick();
    n_checks++;
    if (core_grant !== 4'b0001 || grant_nonce !== 4'd0) begin
      n_fail++;
      $display("FAIL abort_restart: got %b/%0d need 0001/0", core_grant, grant_nonce);
    end
    core_req  = '0;
    job_abort = 1'b1;
    tick();
    job_abort = 1'b0;
  endtask

  task automatic test_masked_req();
    core_req  = 4'b0010;
    job_start = 1'b1;
    tick();
    job_start = 1'b0;
    tick();
    n_checks++;
    if (core_grant !== 4'b0010 || grant_nonce !== 4'd0) begin
      n_fail++;
      $display("FAIL mask_first: got %b/%0d need 0010/0", core_grant, grant_nonce);
    end
    core_req = 4'b1010;
    tick();
    n_checks++;
    if (core_grant !== 4'b1000 || grant_nonce !== 4'd1) begin
      n_fail++;
      $display("FAIL mask_core3: got %b/%0d need 1000/1", core_grant, grant_nonce);
    end
    core_found = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      tick();
      core_found = '0;
      n_checks++;
      if (core_grant !== 4'b0000 || done !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL mask_hold%0d: got grant=%b done=%b busy=%b need 0000/0/1", c, core_grant, done, busy);
      end
    end
    core_done = 4'b0010;
    tick();
    core_done = '0;
    n_checks++;
    if (core_grant !== 4'b0000) begin n_fail++; $display("FAIL mask_done_cycle: got %b need 0000", core_grant); end
    tick();
    n_checks++;
    if (core_grant !== 4'b0010 || grant_nonce !== 4'd2) begin
      n_fail++;
      $display("FAIL mask_regrant: got %b/%0d need 0010/2", core_grant, grant_nonce);
    end
    core_req = '0;
  endtask

  initial begin
    test_reset();
    test_reset_mid_dispatch();
    test_round_robin();
    test_exhaustion();
    test_found();
    test_abort();
    test_masked_req();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/miner_nonce_dispatch.md
# miner_nonce_dispatch

Hands out nonces from a shared 32-bit nonce space to `CORES` hash cores for one mining job. Arbitrates core requests round-robin, tracks which nonce each core holds, and reports the winning core and nonce, or space exhaustion. Sits between the job loader (which pulses `job_start`) and the array of hash cores.

## Interface
- `CORES`, 4: number of hash cores. Minimum 2.
- `NONCE_W`, 32: nonce width. Benches may reduce it to force exhaustion.

- `clk`  in  1  system clock
- `n_rst`  in  1  asynchronous active-low reset
- `job_start`  in  1  pulse; begin a new job at nonce 0
- `job_abort`  in  1  pulse; drop the job from any state
- `core_req`  in  CORES  core i is idle and wants a nonce; held until granted
- `core_done`  in  CORES  pulse; core i finished its nonce without a hit
- `core_found`  in  CORES  pulse; core i's nonce meets target
- `core_grant`  out  CORES  one-hot pulse, registered
- `grant_nonce`  out  NONCE_W  nonce carried with `core_grant`, registered
- `busy`  out  1  a job is in DISPATCH or DRAIN
- `done`  out  1  job finished; held until `job_start` or `job_abort`
- `success`  out  1  valid when `done`; 1 means a nonce was found
- `winner_id`  out  $clog2(CORES)  core that found the nonce
- `winner_nonce`  out  NONCE_W  nonce that was found

## Operation
- States: IDLE, DISPATCH, DRAIN, DONE.
- Reset: state IDLE; all outputs 0; nonce counter 0; round-robin pointer 0; per-core busy bits 0; assigned-nonce array 0.
- **IDLE / DONE**
  - `job_start` → DISPATCH.
  - Clears the nonce counter, pointer, busy bits, `done`, `success`, `winner_id` and `winner_nonce`.
- **DISPATCH**
  - Eligible requests are `core_req[i] & ~busy_bit[i]`. Requests from busy cores are ignored.
  - Pick the first eligible core at or after the pointer, wrapping at `CORES`.
  - Next cycle: `core_grant[i]`=1 and `grant_nonce`=counter.
  - On the same edge: `assigned[i]`←counter, `busy_bit[i]`←1, counter+1, pointer←i+1 mod `CORES`.
  - At most one grant per cycle.
- **Exhaustion**: the grant of nonce 2^NONCE_W−1 moves DISPATCH → DRAIN. The counter does not wrap, and no further grants are issued.
- **DRAIN**: no grants. When all busy bits are 0 → DONE with `success`=0.
- **Busy-bit clearing**: `core_done[i]` clears `busy_bit[i]` in any state.
- **Found**: any `core_found` in DISPATCH or DRAIN → DONE.
  - `success`=1; `winner_id` = lowest asserted index; `winner_nonce` = `assigned[winner_id]`.
  - Simultaneous found and pending grant: found wins and no grant is issued that cycle.
- **Abort**: `job_abort` in any state → IDLE. Clears busy bits and `done`; no grant is issued. Abort has priority over `job_start`, found and done.
- `job_start` in DISPATCH or DRAIN is ignored.
- `core_found`/`core_done` from a core whose busy bit is 0 are ignored.

## Timing
- `job_start` at edge t → `busy`=1 after t. A request present in cycle t+1 is granted visibly after edge t+2.
- Throughput: one grant per cycle with continuous requests.
- A granting core must drop `core_req` the cycle after seeing `core_grant`. Its busy bit already masks a late request.
- `core_found` at edge t → `done`, `success`, `winner_*` valid after t; `busy`=0 at the same time.
- Last `core_done` in DRAIN at edge t → `done`=1 after t.
- `core_grant` and `grant_nonce` hold their value for exactly one cycle. `grant_nonce` returns to 0 when no grant is issued.

## Structure
- `miner_pkg`:
  - state enum typedef `dispatch_state_t`.
  - default `CORES`/`NONCE_W` constants.
- Sub-module `miner_rr_arbiter`, parameterised by `CORES`:
  - Combinational: eligible vector + pointer in; one-hot grant and index out.
  - Pointer register stays in the parent.
- Parent holds the FSM, nonce counter, busy bits and assigned-nonce array.

## Test plan
- Reset mid-DISPATCH (`n_rst` low asynchronously) → all outputs 0 immediately. After release, no grant until `job_start`.
- CORES=4, all `core_req` high, cores drop req after grant → grants to cores 0,1,2,3 with `grant_nonce` 0,1,2,3 on consecutive cycles. Core 0 re-requests after `core_done` and receives nonce 4.
- NONCE_W=4, continuous requests:
  - Nonce 15 granted → DRAIN, no further `core_grant`.
  - After the last `core_done` → `done`=1, `success`=0.
- Core 2 holds nonce 6 and core 3 holds nonce 7; `core_found[2]` and `[3]` in the same cycle → `done`=1, `success`=1, `winner_id`=2, `winner_nonce`=6, with no grant that cycle.
- `job_abort` with 2 cores busy in DISPATCH → IDLE next cycle, `busy`=0. A following `job_start` restarts grants at nonce 0 from core 0.
- Core 1 busy and keeps `core_req[1]` high, core 3 requesting → only core 3 granted until `core_done[1]` pulses.
